i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target with a 4 x 8-bit register file.
// Write: START, addr+W, pointer, data... STOP. Read: START, addr+R, data... NACK, STOP.
// SCL/SDA are oversampled on clk; SDA drive only moves on synced SCL falling edges.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [31:0] regs,
  output logic        wr_valid,
  output logic [1:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // [0],[1] form the synchronizer; [2] is the delayed copy used for edges
  logic [2:0]      r_scl_s, r_sda_s;
  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic            r_rw, w_rw_nxt;
  logic            r_oe, w_oe_nxt;
  logic [3:0][7:0] r_regs, w_regs_nxt;
  logic            r_wr_valid, w_wr_valid_nxt;
  logic [1:0]      r_wr_addr, w_wr_addr_nxt;
  logic [7:0]      r_wr_data, w_wr_data_nxt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl_rise = r_scl_s[1] & ~r_scl_s[2];
  assign w_scl_fall = ~r_scl_s[1] & r_scl_s[2];
  assign w_start    = r_scl_s[1] & r_scl_s[2] & ~r_sda_s[1] & r_sda_s[2];
  assign w_stop     = r_scl_s[1] & r_scl_s[2] & r_sda_s[1] & ~r_sda_s[2];
  // byte as it stands once the current rising-edge bit is shifted in
  assign w_byte     = {r_shift[6:0], r_sda_s[1]};

  // bus synchronizers; reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s <= 3'b111;
      r_sda_s <= 3'b111;
    end else begin
      r_scl_s <= {r_scl_s[1:0], scl_i};
      r_sda_s <= {r_sda_s[1:0], sda_i};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state and datapath; START/STOP override whatever the byte engine is doing
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_rw_nxt       = r_rw;
    w_oe_nxt       = r_oe;
    w_regs_nxt     = r_regs;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = 4'd0;
              if (r_state == ADDR) begin
                w_rw_nxt    = w_byte[0];
                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
              end else if (r_state == PTR) begin
                w_ptr_nxt   = w_byte[1:0];
                w_state_nxt = PTR_ACK;
              end else begin
                w_regs_nxt[r_ptr] = w_byte;
                w_wr_valid_nxt    = 1'b1;
                w_wr_addr_nxt     = r_ptr;
                w_wr_data_nxt     = w_byte;
                w_ptr_nxt         = r_ptr + 2'd1;
                w_state_nxt       = WDATA_ACK;
              end
            end
          end
        end
        // first fall pulls SDA for the ACK slot, second fall ends it
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt  = 1'b0;
              w_cnt_nxt = 4'd0;
              if (r_state == ADDR_ACK && r_rw) begin
                w_shift_nxt = r_regs[r_ptr];
                w_oe_nxt    = ~r_regs[r_ptr][7];
                w_state_nxt = RDATA;
              end else if (r_state == ADDR_ACK) begin
                w_state_nxt = PTR;
              end else begin
                w_state_nxt = WDATA;
              end
            end
          end
        end
        // r_cnt counts bits the master has sampled; r_shift[7] is the bit on the bus
        RDATA: begin
          if (w_scl_rise) w_cnt_nxt = r_cnt + 4'd1;
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = RDATA_ACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end
        end
        // r_cnt==1 marks a received master ACK awaiting the next fall
        RDATA_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_s[1]) begin
              w_state_nxt = IDLE;
            end else begin
              w_ptr_nxt = r_ptr + 2'd1;
              w_cnt_nxt = 4'd1;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_shift_nxt = r_regs[r_ptr];
            w_oe_nxt    = ~r_regs[r_ptr][7];
            w_cnt_nxt   = 4'd0;
            w_state_nxt = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_ptr      <= 2'd0;
      r_rw       <= 1'b0;
      r_oe       <= 1'b0;
      r_regs     <= RST_VAL;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 2'd0;
      r_wr_data  <= 8'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rw       <= w_rw_nxt;
      r_oe       <= w_oe_nxt;
      r_regs     <= w_regs_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  assign sda_oe   = r_oe;
  assign regs     = r_regs;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = (r_state != IDLE);

endmodule
